// File: rtl/demux_dispatch_if.sv
// demux_dispatch_if
//   Handshake and data bundle of the 1-to-4 dispatch controller.
//   slave  : seen by the controller (accepts words, drives channel outputs)
//   master : seen by the environment (offers words, sinks channel outputs)
//   in_valid/in_ready/in_data/in_dest/mode : upstream word offer
//   out_valid/out_ready/out_data           : four downstream channels
//   sel                                    : channel of the word held
//   xfer_cnt                               : per-channel 8-bit transfer counts
interface demux_dispatch_if #(
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [1:0]     in_dest;
    logic           mode;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [4*W-1:0] out_data;
    logic [1:0]     sel;
    logic [4*8-1:0] xfer_cnt;

    modport slave (
        input  in_valid, in_data, in_dest, mode, out_ready,
        output in_ready, out_valid, out_data, sel, xfer_cnt
    );

    modport master (
        output in_valid, in_data, in_dest, mode, out_ready,
        input  in_ready, out_valid, out_data, sel, xfer_cnt
    );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl
//   Single-entry dispatcher: holds one word and presents it on one of four
//   channels, chosen either by in_dest (mode=0) or by a round-robin pointer
//   (mode=1). A new word may be accepted on the same edge the held word
//   completes, giving one word per cycle when the target is ready.
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - demux_dispatch_if.slave (handshake, channel data, sel, counters)

// Per-channel slice: gates the shared hold word onto this channel and keeps
// the channel's completed-transfer counter.
module demux_dispatch_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         active,   // word held and targeted at this channel
    input  logic         done,     // held word leaves on this edge
    input  logic [W-1:0] word,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [7:0]   cnt
);
    assign valid = active;
    assign data  = active ? word : '0;

    // 8-bit counter wraps naturally 255 -> 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (done) cnt <= cnt + 8'd1;
    end
endmodule

module demux_dispatch_ctrl #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    demux_dispatch_if.slave   bus
);
    localparam int NUM_LANES = 4;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t         state;
    logic [1:0]     sel_q;
    logic [1:0]     rr_ptr;
    logic [W-1:0]   hold_q;

    logic                           in_ready_c;
    logic                           accept;
    logic [NUM_LANES-1:0]           sel_oh;
    logic [NUM_LANES-1:0]           lane_active;
    logic [NUM_LANES-1:0]           lane_done;
    logic [NUM_LANES-1:0]           lane_valid;
    logic [NUM_LANES-1:0][W-1:0]    lane_data;
    logic [NUM_LANES-1:0][7:0]      lane_cnt;

    // Ready passes the target's ready straight through while holding, so the
    // hold slot is refilled on the very edge it drains. Forced low in reset.
    assign in_ready_c = rst_n & ((state == IDLE) | bus.out_ready[sel_q]);
    assign accept     = bus.in_valid & in_ready_c;

    always_comb begin
        sel_oh        = '0;
        sel_oh[sel_q] = 1'b1;
    end

    // Only the selected channel's ready matters; the others are masked here.
    assign lane_active = (state == HOLD) ? sel_oh : '0;
    assign lane_done   = lane_active & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel_q  <= 2'd0;
            rr_ptr <= 2'd0;
            hold_q <= '0;
        end else if (accept) begin
            // mode/in_dest are consumed only here; later changes cannot
            // retarget the held word.
            hold_q <= bus.in_data;
            sel_q  <= bus.mode ? rr_ptr : bus.in_dest;
            if (bus.mode) rr_ptr <= rr_ptr + 2'd1;
            state  <= HOLD;
        end else if (|lane_done) begin
            state  <= IDLE;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        demux_dispatch_lane #(.W(W)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .active (lane_active[k]),
            .done   (lane_done[k]),
            .word   (hold_q),
            .valid  (lane_valid[k]),
            .data   (lane_data[k]),
            .cnt    (lane_cnt[k])
        );
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = lane_valid;
    assign bus.out_data  = lane_data;
    assign bus.sel       = sel_q;
    assign bus.xfer_cnt  = lane_cnt;
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl
//   Directed scenarios with literal expectations, then a randomized phase.
//   A behavioural model (held word, target channel, rr pointer, counters)
//   is checked against every output on every falling edge.
module tb_demux_dispatch_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    demux_dispatch_if #(.W(W)) bus();

    demux_dispatch_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_held;
    int        m_ch;
    int        m_rr;
    int        m_word;
    int        m_cnt [4];

    always @(negedge clk) begin
        logic           e_rdy;
        logic [3:0]     e_vld;
        logic [4*W-1:0] e_data;
        logic [31:0]    e_cnt;
        bit             done, acc;
        if (!rst_n) begin
            m_held = 0; m_ch = 0; m_rr = 0; m_word = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end
        e_rdy  = rst_n && (!m_held || bus.out_ready[m_ch]);
        e_vld  = m_held ? (4'b0001 << m_ch) : 4'b0000;
        e_data = '0;
        if (m_held) e_data[m_ch*W +: W] = m_word[W-1:0];
        for (int i = 0; i < 4; i++) e_cnt[i*8 +: 8] = m_cnt[i][7:0];
        chk("m_in_ready",  bus.in_ready,  e_rdy);
        chk("m_out_valid", bus.out_valid, e_vld);
        chk("m_out_data",  bus.out_data,  e_data);
        chk("m_sel",       bus.sel,       m_ch[1:0]);
        chk("m_xfer_cnt",  bus.xfer_cnt,  e_cnt);
        // advance to the state that must hold after the coming rising edge
        if (rst_n) begin
            done = m_held && bus.out_ready[m_ch];
            acc  = bus.in_valid && e_rdy;
            if (done) m_cnt[m_ch] = (m_cnt[m_ch] + 1) % 256;
            if (acc) begin
                m_word = bus.in_data;
                m_ch   = bus.mode ? m_rr : bus.in_dest;
                if (bus.mode) m_rr = (m_rr + 1) % 4;
                m_held = 1;
            end else if (done) begin
                m_held = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic offer(input logic v, input logic md, input logic [1:0] d,
                         input logic [W-1:0] data, input logic [3:0] ordy);
        bus.in_valid  = v;
        bus.mode      = md;
        bus.in_dest   = d;
        bus.in_data   = data;
        bus.out_ready = ordy;
    endtask

    initial begin
        rst_n = 1'b0;
        offer(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);

        // reset state
        at_neg();
        chk("rst_in_ready",  bus.in_ready,  1'b0);
        chk("rst_out_valid", bus.out_valid, 4'b0000);
        chk("rst_out_data",  bus.out_data,  32'h0);
        chk("rst_xfer_cnt",  bus.xfer_cnt,  32'h0);
        cyc(); rst_n = 1'b1;
        at_neg();
        chk("post_rst_in_ready", bus.in_ready, 1'b1);

        // addressed mode
        cyc(); offer(1'b1, 1'b0, 2'd2, 8'hA5, 4'hF);
        cyc(); bus.in_valid = 1'b0;
        at_neg();
        chk("addr_out_valid", bus.out_valid, 4'b0100);
        chk("addr_out_data",  bus.out_data,  32'h00A5_0000);
        cyc();
        at_neg();
        chk("addr_xfer_cnt",  bus.xfer_cnt,  32'h0001_0000);
        chk("addr_idle",      bus.out_valid, 4'b0000);

        // round-robin, back to back
        cyc(); offer(1'b1, 1'b1, 2'd0, 8'h11, 4'hF);
        at_neg(); chk("rr_ready0", bus.in_ready, 1'b1);
        cyc(); bus.in_data = 8'h22;
        at_neg(); chk("rr_v0", bus.out_valid, 4'b0001); chk("rr_d0", bus.out_data, 32'h0000_0011);
        chk("rr_ready1", bus.in_ready, 1'b1);
        cyc(); bus.in_data = 8'h33;
        at_neg(); chk("rr_v1", bus.out_valid, 4'b0010); chk("rr_d1", bus.out_data, 32'h0000_2200);
        chk("rr_ready2", bus.in_ready, 1'b1);
        cyc(); bus.in_data = 8'h44;
        at_neg(); chk("rr_v2", bus.out_valid, 4'b0100); chk("rr_d2", bus.out_data, 32'h0033_0000);
        chk("rr_ready3", bus.in_ready, 1'b1);
        cyc(); bus.in_data = 8'h55;
        at_neg(); chk("rr_v3", bus.out_valid, 4'b1000); chk("rr_d3", bus.out_data, 32'h4400_0000);
        cyc(); bus.in_valid = 1'b0;
        at_neg(); chk("rr_v4_wrap", bus.out_valid, 4'b0001); chk("rr_d4", bus.out_data, 32'h0000_0055);
        cyc();
        at_neg(); chk("rr_cnt", bus.xfer_cnt, 32'h0102_0102);

        // backpressure on channel 1; mode/dest changes while holding ignored
        cyc(); offer(1'b1, 1'b0, 2'd1, 8'h5A, 4'b1101);
        cyc(); bus.in_data = 8'h77; bus.in_dest = 2'd3; bus.mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("bp_in_ready",  bus.in_ready,  1'b0);
            chk("bp_out_valid", bus.out_valid, 4'b0010);
            chk("bp_out_data",  bus.out_data,  32'h0000_5A00);
            cyc();
        end
        bus.out_ready = 4'hF; bus.in_valid = 1'b0;
        at_neg(); chk("bp_release_ready", bus.in_ready, 1'b1);
        cyc();
        at_neg();
        chk("bp_cnt",  bus.xfer_cnt,  32'h0102_0202);
        chk("bp_idle", bus.out_valid, 4'b0000);

        // counter wrap on channel 3: 1 + 255 -> 0
        cyc(); offer(1'b1, 1'b0, 2'd3, 8'h3C, 4'hF);
        for (int i = 0; i < 255; i++) begin
            cyc(); bus.in_data = W'($urandom);
        end
        bus.in_valid = 1'b0;
        cyc();
        at_neg(); chk("wrap_cnt", bus.xfer_cnt, 32'h0002_0202);

        // reset while holding
        cyc(); offer(1'b1, 1'b0, 2'd2, 8'hC3, 4'b1011);
        cyc(); bus.in_valid = 1'b0;
        at_neg(); chk("mr_hold", bus.out_valid, 4'b0100);
        cyc(); rst_n = 1'b0;
        at_neg();
        chk("mr_out_valid", bus.out_valid, 4'b0000);
        chk("mr_in_ready",  bus.in_ready,  1'b0);
        chk("mr_out_data",  bus.out_data,  32'h0);
        chk("mr_cnt",       bus.xfer_cnt,  32'h0);
        cyc(); rst_n = 1'b1; offer(1'b1, 1'b1, 2'd3, 8'h99, 4'hF);
        at_neg(); chk("mr_ready", bus.in_ready, 1'b1);
        cyc(); bus.in_valid = 1'b0;
        at_neg(); chk("mr_rr_ch0", bus.out_valid, 4'b0001); chk("mr_data", bus.out_data, 32'h0000_0099);
        cyc();
        at_neg(); chk("mr_cnt_after", bus.xfer_cnt, 32'h0000_0001);

        // randomized phase, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst_n         = ($urandom_range(0, 299) != 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.mode      = 1'($urandom);
            bus.in_dest   = 2'($urandom);
            bus.in_data   = W'($urandom);
            bus.out_ready = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
        end
        cyc(); rst_n = 1'b1; bus.in_valid = 1'b0;
        at_neg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
